// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pointer defaults and the ALU B-operand source encoding.
package cpu_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam logic [15:0] RESET_IP_DEF = 16'h0000;
  localparam logic [15:0] RESET_DP_DEF = 16'h0000;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_B    = 2'd1,
    SRC_PL   = 2'd2,
    SRC_PH   = 2'd3
  } alu_src_e;

  // Priority decode of the active-low output enables: PL > PH > B > zero.
  function automatic alu_src_e decode_alu_src(input logic n_pl, input logic n_ph,
                                              input logic n_b);
    if (!n_pl)      return SRC_PL;
    else if (!n_ph) return SRC_PH;
    else if (!n_b)  return SRC_B;
    else            return SRC_ZERO;
  endfunction

  // True when more than one of the active-low enables is asserted.
  function automatic logic oe_conflict(input logic [3:0] n_oe);
    logic [3:0] low;
    low = ~n_oe;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/ptr_reg16.sv
// 16-bit pointer register: word load, per-byte load, increment with carry-out.
// Byte loads are applied after the word-load/increment choice, so they always
// modify whatever value the register is about to take.
module ptr_reg16 #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_ce,
  input  logic        i_inc,
  input  logic        i_ld_word,
  input  logic [15:0] i_word,
  input  logic        i_ld_lo,
  input  logic        i_ld_hi,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_q,
  output logic [15:0] o_q_inc,
  output logic        o_carry
);

  logic [15:0] r_q;
  logic [15:0] w_next;

  // Current value plus optional increment; the 17th bit is the wrap carry.
  assign {o_carry, o_q_inc} = {1'b0, r_q} + {16'd0, i_inc};
  assign o_q = r_q;

  // Next value: word load or incremented value, then byte overlays.
  always_comb begin
    w_next = i_ld_word ? i_word : o_q_inc;
    if (i_ld_lo) w_next[7:0]  = i_byte;
    if (i_ld_hi) w_next[15:8] = i_byte;
  end

  // State register with synchronous active-low reset and advance strobe.
  always_ff @(posedge clk) begin
    if (!n_rst)    r_q <= RESET_VAL;
    else if (i_ce) r_q <= w_next;
  end

endmodule

// File: rtl/pointer_unit.sv
// IP/DP pointer pair: drives the address bus, feeds PL/PH to the ALU B mux,
// and tracks IP wrap and ALU-select conflicts.
module pointer_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter logic [15:0] RESET_IP = RESET_IP_DEF,
  parameter logic [15:0] RESET_DP = RESET_DP_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              ce,
  input  logic              ip_inc,
  input  logic              swap_p,
  input  logic              addr_dp,
  input  logic              n_we_pl,
  input  logic              n_we_ph,
  input  logic [7:0]        di,
  input  logic              n_oe_pl_alu,
  input  logic              n_oe_ph_alu,
  input  logic              n_oe_b_alu,
  input  logic              n_oe_zero_alu,
  input  logic [7:0]        b_in,
  input  logic              clr_wrap,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        alu_b,
  output logic [ADDR_W-1:0] ip,
  output logic [ADDR_W-1:0] dp,
  output logic              ip_wrap,
  output logic              sel_err
);

  logic [15:0] w_ip_q;
  logic [15:0] w_ip_inc;
  logic        w_ip_carry;
  logic [15:0] w_dp_q;
  logic [15:0] w_dp_inc;
  logic        w_dp_carry;
  logic        w_unused_dp;
  alu_src_e    w_src;
  logic        r_ip_wrap;
  logic        r_sel_err;

  // IP: increments, or takes the old DP on a swap (untouched by byte writes).
  ptr_reg16 #(.RESET_VAL(RESET_IP)) u_ip (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_ce      (ce),
    .i_inc     (ip_inc),
    .i_ld_word (swap_p),
    .i_word    (w_dp_q),
    .i_ld_lo   (1'b0),
    .i_ld_hi   (1'b0),
    .i_byte    (8'h00),
    .o_q       (w_ip_q),
    .o_q_inc   (w_ip_inc),
    .o_carry   (w_ip_carry)
  );

  // DP: on a swap takes the already-incremented IP (return address); byte
  // writes then land on that post-swap value.
  ptr_reg16 #(.RESET_VAL(RESET_DP)) u_dp (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_ce      (ce),
    .i_inc     (1'b0),
    .i_ld_word (swap_p),
    .i_word    (w_ip_inc),
    .i_ld_lo   (~n_we_pl),
    .i_ld_hi   (~n_we_ph),
    .i_byte    (di),
    .o_q       (w_dp_q),
    .o_q_inc   (w_dp_inc),
    .o_carry   (w_dp_carry)
  );

  // DP never increments, so its adder outputs carry no information.
  assign w_unused_dp = ^{w_dp_inc, w_dp_carry};

  assign ip      = w_ip_q;
  assign dp      = w_dp_q;
  assign addr    = addr_dp ? w_dp_q : w_ip_q;
  assign ip_wrap = r_ip_wrap;
  assign sel_err = r_sel_err;

  assign w_src = decode_alu_src(n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu);

  // ALU B operand mux, zero latency from the selects.
  always_comb begin
    alu_b = 8'h00;
    case (w_src)
      SRC_PL:   alu_b = w_dp_q[7:0];
      SRC_PH:   alu_b = w_dp_q[15:8];
      SRC_B:    alu_b = b_in;
      default:  alu_b = 8'h00;
    endcase
  end

  // Sticky wrap flag (set beats clear) and sticky select-conflict flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ip_wrap <= 1'b0;
      r_sel_err <= 1'b0;
    end else if (ce) begin
      if (w_ip_carry)    r_ip_wrap <= 1'b1;
      else if (clr_wrap) r_ip_wrap <= 1'b0;
      if (oe_conflict({n_oe_pl_alu, n_oe_ph_alu, n_oe_b_alu, n_oe_zero_alu}))
        r_sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pointer_unit.sv
// Directed self-checking bench for pointer_unit.
module tb_pointer_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        ce;
  logic        ip_inc;
  logic        swap_p;
  logic        addr_dp;
  logic        n_we_pl;
  logic        n_we_ph;
  logic [7:0]  di;
  logic        n_oe_pl_alu;
  logic        n_oe_ph_alu;
  logic        n_oe_b_alu;
  logic        n_oe_zero_alu;
  logic [7:0]  b_in;
  logic        clr_wrap;
  logic [15:0] addr;
  logic [7:0]  alu_b;
  logic [15:0] ip;
  logic [15:0] dp;
  logic        ip_wrap;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  pointer_unit dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .ce            (ce),
    .ip_inc        (ip_inc),
    .swap_p        (swap_p),
    .addr_dp       (addr_dp),
    .n_we_pl       (n_we_pl),
    .n_we_ph       (n_we_ph),
    .di            (di),
    .n_oe_pl_alu   (n_oe_pl_alu),
    .n_oe_ph_alu   (n_oe_ph_alu),
    .n_oe_b_alu    (n_oe_b_alu),
    .n_oe_zero_alu (n_oe_zero_alu),
    .b_in          (b_in),
    .clr_wrap      (clr_wrap),
    .addr          (addr),
    .alu_b         (alu_b),
    .ip            (ip),
    .dp            (dp),
    .ip_wrap       (ip_wrap),
    .sel_err       (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
    $display("check %-12s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_dp(input logic [15:0] v);
    di = v[7:0];
    n_we_pl = 1'b0;
    step();
    n_we_pl = 1'b1;
    di = v[15:8];
    n_we_ph = 1'b0;
    step();
    n_we_ph = 1'b1;
  endtask

  task automatic do_swap();
    swap_p = 1'b1;
    step();
    swap_p = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; ce = 1'b1; ip_inc = 1'b1; swap_p = 1'b0; addr_dp = 1'b0;
    n_we_pl = 1'b1; n_we_ph = 1'b1; di = 8'h00;
    n_oe_pl_alu = 1'b1; n_oe_ph_alu = 1'b1; n_oe_b_alu = 1'b1; n_oe_zero_alu = 1'b1;
    b_in = 8'h00; clr_wrap = 1'b0;

    // Reset held two cycles while increment is requested.
    step();
    step();
    chk("rst_ip", ip, 16'h0000);
    chk("rst_dp", dp, 16'h0000);
    chk("rst_addr", addr, 16'h0000);
    chk("rst_wrap", {15'd0, ip_wrap}, 16'h0000);
    chk("rst_selerr", {15'd0, sel_err}, 16'h0000);
    chk("rst_alub", {8'd0, alu_b}, 16'h0000);

    // Bring IP to FFFE via DP load and swap.
    n_rst = 1'b1;
    ip_inc = 1'b0;
    load_dp(16'hFFFE);
    do_swap();
    chk("ip_fffe", ip, 16'hFFFE);
    chk("dp_after_sw", dp, 16'h0000);

    // Increment across the wrap.
    ip_inc = 1'b1;
    step();
    chk("ip_ffff", ip, 16'hFFFF);
    chk("wrap_pre", {15'd0, ip_wrap}, 16'h0000);
    step();
    chk("ip_wrap0", ip, 16'h0000);
    chk("wrap_set", {15'd0, ip_wrap}, 16'h0001);
    ip_inc = 1'b0;
    clr_wrap = 1'b1;
    step();
    clr_wrap = 1'b0;
    chk("wrap_clr", {15'd0, ip_wrap}, 16'h0000);

    // DP byte loads and ALU B selects.
    load_dp(16'h1234);
    chk("dp_1234", dp, 16'h1234);
    chk("addr_ip", addr, 16'h0000);
    addr_dp = 1'b1;
    #1;
    chk("addr_dp", addr, 16'h1234);
    n_oe_ph_alu = 1'b0;
    #1;
    chk("alub_ph", {8'd0, alu_b}, 16'h0012);
    n_oe_ph_alu = 1'b1;
    n_oe_pl_alu = 1'b0;
    #1;
    chk("alub_pl", {8'd0, alu_b}, 16'h0034);
    n_oe_pl_alu = 1'b1;
    n_oe_b_alu = 1'b0;
    b_in = 8'h5A;
    #1;
    chk("alub_b", {8'd0, alu_b}, 16'h005A);
    n_oe_b_alu = 1'b1;
    #1;
    chk("alub_zero", {8'd0, alu_b}, 16'h0000);

    // Byte write while addressing through DP: addr moves only after the edge.
    di = 8'h77;
    n_we_pl = 1'b0;
    #1;
    chk("addr_pre_wr", addr, 16'h1234);
    step();
    n_we_pl = 1'b1;
    chk("addr_post_wr", addr, 16'h1277);
    addr_dp = 1'b0;

    // Jump with return: inc + swap.
    load_dp(16'h0100);
    do_swap();
    load_dp(16'h2000);
    chk("jr_ip_pre", ip, 16'h0100);
    ip_inc = 1'b1;
    swap_p = 1'b1;
    step();
    ip_inc = 1'b0;
    swap_p = 1'b0;
    chk("jr_ip", ip, 16'h2000);
    chk("jr_dp", dp, 16'h0101);

    // Swap + low byte write lands on post-swap DP.
    di = 8'h00;
    n_we_pl = 1'b0;
    step();
    n_we_pl = 1'b1;
    do_swap();
    chk("sw_ip_pre", ip, 16'h0100);
    chk("sw_dp_pre", dp, 16'h2000);
    swap_p = 1'b1;
    n_we_pl = 1'b0;
    di = 8'hAA;
    step();
    swap_p = 1'b0;
    n_we_pl = 1'b1;
    chk("swwr_ip", ip, 16'h2000);
    chk("swwr_dp", dp, 16'h01AA);

    // ce=0: everything asserted, nothing changes.
    ce = 1'b0;
    ip_inc = 1'b1; swap_p = 1'b1; n_we_pl = 1'b0; n_we_ph = 1'b0; di = 8'h55;
    n_oe_pl_alu = 1'b0; n_oe_ph_alu = 1'b0; n_oe_b_alu = 1'b0; n_oe_zero_alu = 1'b0;
    step();
    step();
    chk("hold_ip", ip, 16'h2000);
    chk("hold_dp", dp, 16'h01AA);
    chk("hold_selerr", {15'd0, sel_err}, 16'h0000);
    ip_inc = 1'b0; swap_p = 1'b0; n_we_pl = 1'b1; n_we_ph = 1'b1;
    n_oe_ph_alu = 1'b1; n_oe_zero_alu = 1'b1;

    // Select conflict on a ce cycle: PL wins, sel_err sets after the edge.
    ce = 1'b1;
    b_in = 8'h5A;
    #1;
    chk("conf_alub", {8'd0, alu_b}, 16'h00AA);
    chk("conf_pre", {15'd0, sel_err}, 16'h0000);
    step();
    chk("conf_set", {15'd0, sel_err}, 16'h0001);
    n_oe_pl_alu = 1'b1;
    n_oe_b_alu = 1'b1;
    step();
    chk("conf_sticky", {15'd0, sel_err}, 16'h0001);

    // Wrap set beats a simultaneous clear.
    load_dp(16'hFFFF);
    do_swap();
    chk("ip_ffff2", ip, 16'hFFFF);
    ip_inc = 1'b1;
    clr_wrap = 1'b1;
    step();
    ip_inc = 1'b0;
    clr_wrap = 1'b0;
    chk("wrap_win", {15'd0, ip_wrap}, 16'h0001);
    chk("ip_0000b", ip, 16'h0000);

    // Reset in the middle of activity, with ce high.
    n_rst = 1'b0;
    ip_inc = 1'b1;
    step();
    n_rst = 1'b1;
    ip_inc = 1'b0;
    chk("rst2_dp", dp, 16'h0000);
    chk("rst2_wrap", {15'd0, ip_wrap}, 16'h0000);
    chk("rst2_selerr", {15'd0, sel_err}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
